elevator_goal_scheduler: RTL and testbench

Parametrised goal-floor scheduler for the elevator controller. It latches floor call requests and tracks a SCAN-style travel direction (IDLE/UP/DOWN). It publishes a registered goal floor that the motion logic drives toward. It generalises the fixed three-floor combinational goal selector to N floors and adds pending-request memory, request clearing on service, and direction persistence.

---
 rtl/elevator_goal_scheduler.sv | 160 ++++++++++++++++
 tb/tb_elevator_goal_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_goal_scheduler.sv
// Goal-floor scheduler for the elevator: latches floor calls and picks
// a registered goal floor with SCAN-style direction persistence.
module elevator_goal_scheduler #(
    parameter int N_FLOORS = 3,
    parameter int FLOOR_W  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_FLOORS-1:0] req,
    input  logic [FLOOR_W-1:0]  floor,
    input  logic                moving,
    input  logic                served,
    output logic [N_FLOORS-1:0] pending,
    output logic [FLOOR_W-1:0]  goal_floor,
    output logic                goal_valid,
    output logic [1:0]          dir
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10
    } dir_t;

    dir_t                state_q, state_d;
    logic [FLOOR_W-1:0]  goal_q, goal_d;
    logic                valid_q, valid_d;
    logic [N_FLOORS-1:0] pending_q, pending_d;

    logic [FLOOR_W:0]    floor_x;
    logic                floor_ok;
    logic                here;
    logic                has_up, has_dn;
    logic [FLOOR_W-1:0]  up_lo, dn_hi;
    logic [FLOOR_W:0]    dist_up, dist_dn;

    assign floor_x  = {1'b0, floor};
    assign floor_ok = floor_x < (FLOOR_W+1)'(N_FLOORS);

    // Clearing on service takes priority over a same-cycle request.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (served && floor_ok && floor_x == (FLOOR_W+1)'(i)) begin
                pending_d[i] = 1'b0;
            end else if (req[i]) begin
                pending_d[i] = 1'b1;
            end
        end
    end

    // Nearest pending call strictly above and strictly below the cabin.
    always_comb begin
        has_up = 1'b0;
        up_lo  = '0;
        for (int i = N_FLOORS - 1; i >= 0; i--) begin
            if (pending_q[i] && (FLOOR_W+1)'(i) > floor_x) begin
                has_up = 1'b1;
                up_lo  = FLOOR_W'(i);
            end
        end
    end

    always_comb begin
        has_dn = 1'b0;
        dn_hi  = '0;
        here   = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (pending_q[i] && (FLOOR_W+1)'(i) < floor_x) begin
                has_dn = 1'b1;
                dn_hi  = FLOOR_W'(i);
            end
            if (pending_q[i] && (FLOOR_W+1)'(i) == floor_x) begin
                here = 1'b1;
            end
        end
    end

    assign dist_up = {1'b0, up_lo} - floor_x;
    assign dist_dn = floor_x - {1'b0, dn_hi};

    always_comb begin
        state_d = state_q;
        goal_d  = goal_q;
        valid_d = valid_q;
        if (!moving && floor_ok) begin
            if (here) begin
                goal_d  = floor;
                valid_d = 1'b1;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        // Equal distance resolves toward the lower floor.
                        if (has_dn && (!has_up || dist_dn <= dist_up)) begin
                            goal_d  = dn_hi;
                            valid_d = 1'b1;
                            state_d = DOWN;
                        end else if (has_up) begin
                            goal_d  = up_lo;
                            valid_d = 1'b1;
                            state_d = UP;
                        end else begin
                            valid_d = 1'b0;
                        end
                    end
                    UP: begin
                        if (has_up) begin
                            goal_d  = up_lo;
                            valid_d = 1'b1;
                        end else if (has_dn) begin
                            goal_d  = dn_hi;
                            valid_d = 1'b1;
                            state_d = DOWN;
                        end else begin
                            valid_d = 1'b0;
                            state_d = IDLE;
                        end
                    end
                    DOWN: begin
                        if (has_dn) begin
                            goal_d  = dn_hi;
                            valid_d = 1'b1;
                        end else if (has_up) begin
                            goal_d  = up_lo;
                            valid_d = 1'b1;
                            state_d = UP;
                        end else begin
                            valid_d = 1'b0;
                            state_d = IDLE;
                        end
                    end
                    default: begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            goal_q    <= '0;
            valid_q   <= 1'b0;
            state_q   <= IDLE;
        end else begin
            pending_q <= pending_d;
            goal_q    <= goal_d;
            valid_q   <= valid_d;
            state_q   <= state_d;
        end
    end

    assign pending    = pending_q;
    assign goal_floor = goal_q;
    assign goal_valid = valid_q;
    assign dir        = state_q;

endmodule

// File: tb/tb_elevator_goal_scheduler.sv
// Directed bench for elevator_goal_scheduler: 3-floor and 8-floor
// instances, expectations queued on stimulus and popped at sampling.
module tb_elevator_goal_scheduler;

    localparam logic [1:0] D_IDLE = 2'b00;
    localparam logic [1:0] D_UP   = 2'b01;
    localparam logic [1:0] D_DOWN = 2'b10;

    logic       clk = 1'b0;
    logic       rst_n;

    logic [2:0] req3;
    logic [1:0] floor3;
    logic       moving3, served3;
    logic [2:0] pend3;
    logic [1:0] goal3;
    logic       gv3;
    logic [1:0] dir3;

    logic [7:0] req8;
    logic [2:0] floor8;
    logic       moving8, served8;
    logic [7:0] pend8;
    logic [2:0] goal8;
    logic       gv8;
    logic [1:0] dir8;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    elevator_goal_scheduler #(.N_FLOORS(3), .FLOOR_W(2)) u3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .floor(floor3),
        .moving(moving3), .served(served3), .pending(pend3),
        .goal_floor(goal3), .goal_valid(gv3), .dir(dir3)
    );

    elevator_goal_scheduler #(.N_FLOORS(8), .FLOOR_W(3)) u8 (
        .clk(clk), .rst_n(rst_n), .req(req8), .floor(floor8),
        .moving(moving8), .served(served8), .pending(pend8),
        .goal_floor(goal8), .goal_valid(gv8), .dir(dir8)
    );

    task automatic push(input string t, input logic [7:0] e);
        exp_t x;
        x.tag = t;
        x.exp = e;
        sbq.push_back(x);
    endtask

    task automatic chk(input logic [7:0] obs);
        exp_t x;
        n_tests++;
        if (sbq.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty: observed %0h required an expectation", obs);
        end else begin
            x = sbq.pop_front();
            assert (obs === x.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h",
                       x.tag, obs, x.exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req3 = 3'b111; floor3 = 2'd1; moving3 = 1'b0; served3 = 1'b0;
        req8 = 8'hff;  floor8 = 3'd2; moving8 = 1'b0; served8 = 1'b0;
        step(); step(); step();
        push("rst_hold_pend3", 8'h00);
        chk({5'b0, pend3});
        req3 = 3'b000;
        req8 = 8'h00;
        rst_n = 1'b1;
        push("rst_pend3", 8'h00);
        push("rst_goal3", 8'h00);
        push("rst_gv3", 8'h00);
        push("rst_dir3", {6'b0, D_IDLE});
        push("rst_pend8", 8'h00);
        step();
        chk({5'b0, pend3});
        chk({6'b0, goal3});
        chk({7'b0, gv3});
        chk({6'b0, dir3});
        chk(pend8);

        // IDLE, cabin at 1, calls at 0 and 2: tie goes down.
        floor3 = 2'd1;
        req3 = 3'b101;
        push("tie_pend_k1", 8'h05);
        push("tie_gv_k1", 8'h00);
        step();
        req3 = 3'b000;
        chk({5'b0, pend3});
        chk({7'b0, gv3});
        push("tie_goal_k2", 8'h00);
        push("tie_dir_k2", {6'b0, D_DOWN});
        push("tie_gv_k2", 8'h01);
        step();
        chk({6'b0, goal3});
        chk({6'b0, dir3});
        chk({7'b0, gv3});

        // Serve floor 0, then the sweep reverses toward floor 2.
        floor3 = 2'd0;
        served3 = 1'b1;
        push("srv0_pend", 8'h04);
        step();
        served3 = 1'b0;
        chk({5'b0, pend3});
        push("rev_goal", 8'h02);
        push("rev_dir", {6'b0, D_UP});
        step();
        chk({6'b0, goal3});
        chk({6'b0, dir3});

        // Freeze while moving; requests still latch.
        moving3 = 1'b1;
        floor3 = 2'd1;
        req3 = 3'b010;
        push("frz_pend", 8'h06);
        push("frz_goal", 8'h02);
        push("frz_dir", {6'b0, D_UP});
        step();
        req3 = 3'b000;
        chk({5'b0, pend3});
        chk({6'b0, goal3});
        chk({6'b0, dir3});
        step();
        push("frz_goal2", 8'h02);
        chk({6'b0, goal3});
        moving3 = 1'b0;
        push("unfrz_goal", 8'h01);
        push("unfrz_dir", {6'b0, D_UP});
        step();
        chk({6'b0, goal3});
        chk({6'b0, dir3});

        // Same-cycle served and request at the cabin floor: clear wins.
        served3 = 1'b1;
        req3 = 3'b010;
        push("clr_pri_pend", 8'h04);
        step();
        served3 = 1'b0;
        req3 = 3'b000;
        chk({5'b0, pend3});

        // Out-of-range floor: no clear, goal and dir hold.
        floor3 = 2'd3;
        served3 = 1'b1;
        push("inv_pend", 8'h04);
        push("inv_goal", 8'h01);
        push("inv_dir", {6'b0, D_UP});
        step();
        served3 = 1'b0;
        chk({5'b0, pend3});
        chk({6'b0, goal3});
        chk({6'b0, dir3});
        push("inv_goal2", 8'h01);
        push("inv_dir2", {6'b0, D_UP});
        step();
        chk({6'b0, goal3});
        chk({6'b0, dir3});

        // 8-floor UP sweep from floor 2.
        floor8 = 3'd2;
        req8 = 8'b0010_0000;
        step();
        req8 = 8'h00;
        push("up_goal5", 8'h05);
        push("up_dir", {6'b0, D_UP});
        step();
        chk({5'b0, goal8});
        chk({6'b0, dir8});
        req8 = 8'b1000_0001;
        step();
        req8 = 8'h00;
        push("up_pend", 8'ha1);
        push("up_goal5b", 8'h05);
        push("up_dirb", {6'b0, D_UP});
        step();
        chk(pend8);
        chk({5'b0, goal8});
        chk({6'b0, dir8});
        floor8 = 3'd5;
        served8 = 1'b1;
        step();
        served8 = 1'b0;
        push("up_goal7", 8'h07);
        push("up_dir7", {6'b0, D_UP});
        step();
        chk({5'b0, goal8});
        chk({6'b0, dir8});
        floor8 = 3'd7;
        served8 = 1'b1;
        step();
        served8 = 1'b0;
        push("rev_goal0", 8'h00);
        push("rev_dir_dn", {6'b0, D_DOWN});
        push("rev_gv", 8'h01);
        step();
        chk({5'b0, goal8});
        chk({6'b0, dir8});
        chk({7'b0, gv8});
        floor8 = 3'd0;
        served8 = 1'b1;
        step();
        served8 = 1'b0;
        push("end_dir", {6'b0, D_IDLE});
        push("end_gv", 8'h00);
        push("end_goal_hold", 8'h00);
        push("end_pend", 8'h00);
        step();
        chk({6'b0, dir8});
        chk({7'b0, gv8});
        chk({5'b0, goal8});
        chk(pend8);

        // Asynchronous reset mid-operation, away from any clock edge.
        req8 = 8'b0000_1000;
        step();
        req8 = 8'h00;
        step();
        push("pre_rst_gv8", 8'h01);
        chk({7'b0, gv8});
        #2;
        rst_n = 1'b0;
        push("arst_pend3", 8'h00);
        push("arst_goal3", 8'h00);
        push("arst_pend8", 8'h00);
        push("arst_gv8", 8'h00);
        push("arst_dir8", {6'b0, D_IDLE});
        #1;
        chk({5'b0, pend3});
        chk({6'b0, goal3});
        chk(pend8);
        chk({7'b0, gv8});
        chk({6'b0, dir8});
        step();
        rst_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
